// File: rtl/watchdog_reset_requester.sv
// Processor-side watchdog: armed and kicked through PicoBlaze port writes.
// Raises a warning before expiry, then drives a fixed-length reset request pulse.
module watchdog_reset_requester #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned WARN_CYCLES    = 1000,
  parameter int unsigned PULSE_CYCLES   = 16,
  parameter logic [7:0]  BASE_ADDR      = 8'hF0
) (
  input  logic       CLK_IN,
  input  logic       RESET_N_IN,
  input  logic [7:0] PORT_ID,
  input  logic       WRITE_STROBE,
  input  logic [7:0] OUT_PORT,
  output logic [7:0] IN_PORT,
  output logic       WARN_IRQ_OUT,
  output logic       RESET_REQ_OUT
);

  localparam logic [7:0]  CTRL_ADDR   = BASE_ADDR;
  localparam logic [7:0]  KICK_ADDR   = BASE_ADDR + 8'd1;
  localparam logic [7:0]  STATUS_ADDR = BASE_ADDR + 8'd2;
  localparam logic [7:0]  KICK_KEY    = 8'hA5;
  localparam logic [23:0] RELOAD      = 24'(TIMEOUT_CYCLES - 1);
  localparam logic [23:0] WARN_LIM    = 24'(WARN_CYCLES);
  localparam logic [7:0]  PULSE_LAST  = 8'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARMED, FIRE} state_t;

  state_t      state;
  logic [23:0] count;
  logic [7:0]  pulse_cnt;
  logic        timeout_flag;

  logic       ctrl_wr, kick_wr, status_wr, armed;
  logic [7:0] rd_data;

  always_comb begin
    ctrl_wr   = WRITE_STROBE && (PORT_ID == CTRL_ADDR);
    kick_wr   = WRITE_STROBE && (PORT_ID == KICK_ADDR);
    status_wr = WRITE_STROBE && (PORT_ID == STATUS_ADDR);
    armed     = (state == ARMED);
    rd_data   = '0;
    if (PORT_ID == STATUS_ADDR)
      rd_data = {5'b0, timeout_flag, WARN_IRQ_OUT, armed};
    else if (PORT_ID == CTRL_ADDR)
      rd_data = {7'b0, armed};
  end

  always_ff @(posedge CLK_IN) begin
    if (!RESET_N_IN) begin
      state         <= IDLE;
      count         <= '0;
      pulse_cnt     <= '0;
      timeout_flag  <= 1'b0;
      IN_PORT       <= '0;
      WARN_IRQ_OUT  <= 1'b0;
      RESET_REQ_OUT <= 1'b0;
    end else begin
      IN_PORT <= rd_data;
      case (state)
        IDLE: begin
          count         <= '0;
          WARN_IRQ_OUT  <= 1'b0;
          RESET_REQ_OUT <= 1'b0;
          if (status_wr)
            timeout_flag <= 1'b0;
          if (ctrl_wr && OUT_PORT[0]) begin
            state        <= ARMED;
            count        <= RELOAD;
            WARN_IRQ_OUT <= (RELOAD < WARN_LIM);
          end
        end
        ARMED: begin
          RESET_REQ_OUT <= 1'b0;
          if (status_wr)
            timeout_flag <= 1'b0;
          // Priority in the expiry cycle: disable, then valid kick, then bad kick/expiry.
          if (ctrl_wr && !OUT_PORT[0]) begin
            state        <= IDLE;
            count        <= '0;
            WARN_IRQ_OUT <= 1'b0;
          end else if (kick_wr && OUT_PORT == KICK_KEY) begin
            count        <= RELOAD;
            WARN_IRQ_OUT <= (RELOAD < WARN_LIM);
          end else if (kick_wr || count == '0) begin
            state         <= FIRE;
            count         <= '0;
            pulse_cnt     <= PULSE_LAST;
            timeout_flag  <= 1'b1;
            WARN_IRQ_OUT  <= 1'b0;
            RESET_REQ_OUT <= 1'b1;
          end else begin
            count        <= count - 24'd1;
            WARN_IRQ_OUT <= ((count - 24'd1) < WARN_LIM);
          end
        end
        FIRE: begin
          WARN_IRQ_OUT <= 1'b0;
          if (pulse_cnt == '0) begin
            state         <= IDLE;
            RESET_REQ_OUT <= 1'b0;
          end else begin
            pulse_cnt     <= pulse_cnt - 8'd1;
            RESET_REQ_OUT <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          count         <= '0;
          WARN_IRQ_OUT  <= 1'b0;
          RESET_REQ_OUT <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_watchdog_reset_requester.sv
// Bench for watchdog_reset_requester: deadline-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_watchdog_reset_requester;

  localparam int T = 20;
  localparam int W = 5;
  localparam int P = 4;
  localparam logic [7:0] F0 = 8'hF0;
  localparam logic [7:0] F1 = 8'hF1;
  localparam logic [7:0] F2 = 8'hF2;

  logic       clk = 1'b0;
  logic       RESET_N_IN = 1'b0;
  logic [7:0] PORT_ID = 8'h00;
  logic       WRITE_STROBE = 1'b0;
  logic [7:0] OUT_PORT = 8'h00;
  logic [7:0] IN_PORT;
  logic       WARN_IRQ_OUT;
  logic       RESET_REQ_OUT;

  watchdog_reset_requester #(
    .TIMEOUT_CYCLES(T),
    .WARN_CYCLES(W),
    .PULSE_CYCLES(P),
    .BASE_ADDR(8'hF0)
  ) dut (
    .CLK_IN(clk),
    .RESET_N_IN(RESET_N_IN),
    .PORT_ID(PORT_ID),
    .WRITE_STROBE(WRITE_STROBE),
    .OUT_PORT(OUT_PORT),
    .IN_PORT(IN_PORT),
    .WARN_IRQ_OUT(WARN_IRQ_OUT),
    .RESET_REQ_OUT(RESET_REQ_OUT)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: mode 0=idle 1=armed 2=firing; expiry tracked as absolute edge numbers.
  int   n = 0;
  int   mode = 0;
  int   deadline = 0;
  int   fire_end = 0;
  bit   mflag = 0, mwarn = 0, mreq = 0, chk_en = 0;
  logic [7:0] mrd = 8'h00;

  always @(posedge clk) begin
    logic w, r;
    logic [7:0] id, d;
    w = WRITE_STROBE; id = PORT_ID; d = OUT_PORT; r = RESET_N_IN;
    if (id == F2)      mrd = {5'b0, mflag, mwarn, mode == 1};
    else if (id == F0) mrd = {7'b0, mode == 1};
    else               mrd = 8'h00;
    if (!r) begin
      mode = 0; mflag = 0; mrd = 8'h00; chk_en = 1;
    end else begin
      case (mode)
        0: begin
          if (w && id == F2) mflag = 0;
          if (w && id == F0 && d[0]) begin mode = 1; deadline = n + T; end
        end
        1: begin
          if (w && id == F2) mflag = 0;
          if (w && id == F0 && !d[0]) mode = 0;
          else if (w && id == F1 && d == 8'hA5) deadline = n + T;
          else if ((w && id == F1) || n == deadline) begin
            mode = 2; fire_end = n + P; mflag = 1;
          end
        end
        default: if (n == fire_end) mode = 0;
      endcase
    end
    mwarn = (mode == 1) && ((deadline - 1 - n) < W);
    mreq  = (mode == 2);
    n++;
    #1;
    if (chk_en) begin
      check("model_in_port", IN_PORT, mrd);
      check("model_warn", 8'(WARN_IRQ_OUT), 8'(mwarn));
      check("model_req", 8'(RESET_REQ_OUT), 8'(mreq));
    end
  end

  task automatic wr(input logic [7:0] id, input logic [7:0] d);
    PORT_ID = id; OUT_PORT = d; WRITE_STROBE = 1'b1;
    @(negedge clk);
    WRITE_STROBE = 1'b0; PORT_ID = 8'h00; OUT_PORT = 8'h00;
  endtask

  task automatic rd(input logic [7:0] id, input logic [7:0] exp, input string name);
    PORT_ID = id;
    @(negedge clk);
    PORT_ID = 8'h00;
    check(name, IN_PORT, exp);
  endtask

  initial begin
    // Reset and idle state
    repeat (3) @(negedge clk);
    RESET_N_IN = 1'b1;
    @(negedge clk);
    check("rst_warn", 8'(WARN_IRQ_OUT), 8'h00);
    check("rst_req", 8'(RESET_REQ_OUT), 8'h00);
    check("rst_in_port", IN_PORT, 8'h00);
    rd(F2, 8'h00, "rst_status");

    // Arm and let it expire
    wr(F0, 8'h01);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      check("expire_warn", 8'(WARN_IRQ_OUT), 8'((k >= 15 && k < 20) ? 1 : 0));
      check("expire_req", 8'(RESET_REQ_OUT), 8'((k >= 20 && k < 24) ? 1 : 0));
    end
    rd(F2, 8'h04, "expire_status");
    rd(F0, 8'h00, "expire_ctrl");
    wr(F2, 8'h00);

    // Regular kicks keep it quiet
    wr(F0, 8'h01);
    rd(F0, 8'h01, "armed_ctrl");
    for (int i = 0; i < 20; i++) begin
      repeat (8) begin
        @(negedge clk);
        check("kick_req", 8'(RESET_REQ_OUT), 8'h00);
        check("kick_warn", 8'(WARN_IRQ_OUT), 8'h00);
      end
      wr(F1, 8'hA5);
    end
    wr(F0, 8'h00);

    // Kick exactly on the expiry edge, then disable on the next expiry edge
    wr(F0, 8'h01);
    repeat (19) @(negedge clk);
    wr(F1, 8'hA5);
    check("edge_kick_req", 8'(RESET_REQ_OUT), 8'h00);
    repeat (19) @(negedge clk);
    check("reload_req", 8'(RESET_REQ_OUT), 8'h00);
    check("reload_warn", 8'(WARN_IRQ_OUT), 8'h01);
    wr(F0, 8'h00);
    check("edge_dis_req", 8'(RESET_REQ_OUT), 8'h00);
    check("edge_dis_warn", 8'(WARN_IRQ_OUT), 8'h00);
    repeat (3) begin
      @(negedge clk);
      check("dis_quiet_req", 8'(RESET_REQ_OUT), 8'h00);
    end
    rd(F2, 8'h00, "dis_status");

    // Bad kick fires immediately; status write during the pulse is ignored
    wr(F0, 8'h01);
    wr(F1, 8'h3C);
    check("bad_req0", 8'(RESET_REQ_OUT), 8'h01);
    wr(F2, 8'h00);
    check("bad_req1", 8'(RESET_REQ_OUT), 8'h01);
    rd(F2, 8'h04, "bad_status_fire");
    @(negedge clk);
    check("bad_req3", 8'(RESET_REQ_OUT), 8'h01);
    @(negedge clk);
    check("bad_req_end", 8'(RESET_REQ_OUT), 8'h00);
    wr(F2, 8'h00);
    rd(F2, 8'h00, "bad_status_clr");

    // Reset during the second pulse cycle
    wr(F0, 8'h01);
    wr(F1, 8'h00);
    @(negedge clk);
    check("mid_fire_req", 8'(RESET_REQ_OUT), 8'h01);
    RESET_N_IN = 1'b0;
    @(negedge clk);
    check("rst_fire_req", 8'(RESET_REQ_OUT), 8'h00);
    RESET_N_IN = 1'b1;
    rd(F2, 8'h00, "rst_fire_status");

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int unsigned pr, sel;
      logic [7:0] ids [5];
      ids[0] = F0; ids[1] = F1; ids[2] = F2; ids[3] = 8'hF3; ids[4] = 8'($urandom);
      pr  = ((i / 400) % 2 == 1) ? 3 : 20;
      sel = $urandom_range(0, 4);
      RESET_N_IN   = ($urandom_range(0, 299) != 0);
      PORT_ID      = ids[sel];
      WRITE_STROBE = ($urandom_range(0, 99) < pr);
      OUT_PORT     = 8'($urandom);
      if (sel == 1 && $urandom_range(0, 9) < 7) OUT_PORT = 8'hA5;
      @(negedge clk);
    end
    WRITE_STROBE = 1'b0;
    PORT_ID = 8'h00;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
